// File: rtl/run_monitor_pkg.sv
// +----------------------------------------------------------------------------+
// | run_monitor_pkg : shared types for the core run monitor  (rev 1.0)         |
// +----------------------------------------------------------------------------+
`default_nettype none

package run_monitor_pkg;

  typedef enum logic [2:0] {
    RUNNING = 3'd0,
    PASS    = 3'd1,
    FAIL    = 3'd2,
    TIMEOUT = 3'd3,
    HANG    = 3'd4
  } run_status_t;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned TOHOST_PASS = 1;

endpackage : run_monitor_pkg

`default_nettype wire

// File: rtl/pc_trace_buf.sv
// +----------------------------------------------------------------------------+
// | pc_trace_buf : ring buffer of the most recent retired PCs  (rev 1.0)       |
// +----------------------------------------------------------------------------+
`default_nettype none

module pc_trace_buf #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TRACE_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [XLEN-1:0]                wr_pc,
  input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
  output logic [XLEN-1:0]                rd_pc
);

  localparam int unsigned IDX_W = $clog2(TRACE_DEPTH);

  logic [XLEN-1:0]  mem_q [TRACE_DEPTH];
  logic [IDX_W-1:0] wr_ptr_q;
  logic [IDX_W-1:0] wr_ptr_d;
  logic [IDX_W-1:0] rd_addr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_pc;
      end
    end
  end

  // wr_ptr_q points one past the newest entry; the subtraction wraps naturally.
  always_comb begin
    rd_addr = wr_ptr_q - IDX_W'(1) - rd_idx;
    rd_pc   = mem_q[rd_addr];
  end

endmodule : pc_trace_buf

`default_nettype wire

// File: rtl/core_run_monitor.sv
// +----------------------------------------------------------------------------+
// | core_run_monitor : core reset sequencer and end-of-run verdict  (rev 1.0)  |
// | Optional PC trace buffer enabled by defining RUN_MONITOR_TRACE_EN.         |
// +----------------------------------------------------------------------------+
`default_nettype none

module core_run_monitor
  import run_monitor_pkg::*;
#(
  parameter int unsigned    XLEN         = 32,
  parameter int unsigned    CNT_W        = 32,
  parameter int unsigned    RESET_CYCLES = 4,
  parameter int unsigned    MAX_CYCLES   = 2500,
  parameter int unsigned    HANG_LIMIT   = 64,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(32'h0000_0FFC),
  parameter int unsigned    TRACE_DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              core_rst,
  input  logic              pc_valid,
  input  logic [XLEN-1:0]   pc,
  input  logic              mem_we,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic              done,
  output run_status_t       status,
  output logic [XLEN-1:0]   exit_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret
`ifdef RUN_MONITOR_TRACE_EN
  ,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [XLEN-1:0]                trace_pc
`endif
);

  localparam int unsigned RST_CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned HANG_W    = (HANG_LIMIT > 1) ? $clog2(HANG_LIMIT) : 1;

  generate
    if (RESET_CYCLES < 1 || HANG_LIMIT < 1 || MAX_CYCLES < 1) begin : g_bad_limits
      $error("core_run_monitor: RESET_CYCLES, HANG_LIMIT and MAX_CYCLES must be >= 1");
    end
    if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("core_run_monitor: TRACE_DEPTH must be a power of two >= 2");
    end
  endgenerate

  state_t               state_q,       state_d;
  logic [RST_CNT_W-1:0] rst_cnt_q,     rst_cnt_d;
  logic                 core_rst_q,    core_rst_d;
  logic                 done_q,        done_d;
  run_status_t          status_q,      status_d;
  logic [XLEN-1:0]      exit_code_q,   exit_code_d;
  logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]     instret_q,     instret_d;
  logic [HANG_W-1:0]    hang_cnt_q,    hang_cnt_d;
  logic [XLEN-1:0]      last_pc_q,     last_pc_d;

  logic progress;
  logic tohost_hit;
  logic hang_hit;
  logic timeout_hit;

  always_comb begin
    progress    = pc_valid && (pc != last_pc_q);
    tohost_hit  = mem_we && (mem_addr == TOHOST_ADDR);
    hang_hit    = !progress && (hang_cnt_q == HANG_W'(HANG_LIMIT - 1));
    timeout_hit = (cycle_count_q == CNT_W'(MAX_CYCLES - 1));
  end

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    core_rst_d    = core_rst_q;
    done_d        = done_q;
    status_d      = status_q;
    exit_code_d   = exit_code_q;
    cycle_count_d = cycle_count_q;
    instret_d     = instret_q;
    hang_cnt_d    = hang_cnt_q;
    last_pc_d     = last_pc_q;

    case (state_q)
      RESET: begin
        if (rst_cnt_q == RST_CNT_W'(RESET_CYCLES - 1)) begin
          state_d    = RUN;
          core_rst_d = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      RUN: begin
        if (cycle_count_q != '1) begin
          cycle_count_d = cycle_count_q + 1'b1;
        end
        if (pc_valid) begin
          last_pc_d = pc;
          if (instret_q != '1) begin
            instret_d = instret_q + 1'b1;
          end
        end
        hang_cnt_d = progress ? '0 : hang_cnt_q + 1'b1;

        // A tohost store outranks a hang, which outranks a timeout, on the same edge.
        if (tohost_hit) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (mem_wdata == XLEN'(TOHOST_PASS)) begin
            status_d = PASS;
          end else begin
            status_d    = FAIL;
            exit_code_d = mem_wdata >> 1;
          end
        end else if (hang_hit) begin
          state_d  = DONE;
          done_d   = 1'b1;
          status_d = HANG;
        end else if (timeout_hit) begin
          state_d  = DONE;
          done_d   = 1'b1;
          status_d = TIMEOUT;
        end
      end

      DONE: begin
        state_d = DONE;
      end

      default: begin
        state_d = RESET;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RESET;
      rst_cnt_q     <= '0;
      core_rst_q    <= 1'b1;
      done_q        <= 1'b0;
      status_q      <= RUNNING;
      exit_code_q   <= '0;
      cycle_count_q <= '0;
      instret_q     <= '0;
      hang_cnt_q    <= '0;
      last_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      core_rst_q    <= core_rst_d;
      done_q        <= done_d;
      status_q      <= status_d;
      exit_code_q   <= exit_code_d;
      cycle_count_q <= cycle_count_d;
      instret_q     <= instret_d;
      hang_cnt_q    <= hang_cnt_d;
      last_pc_q     <= last_pc_d;
    end
  end

  assign core_rst    = core_rst_q;
  assign done        = done_q;
  assign status      = status_q;
  assign exit_code   = exit_code_q;
  assign cycle_count = cycle_count_q;
  assign instret     = instret_q;

`ifdef RUN_MONITOR_TRACE_EN
  logic trace_we;

  assign trace_we = (state_q == RUN) && pc_valid;

  pc_trace_buf #(
    .XLEN        (XLEN),
    .TRACE_DEPTH (TRACE_DEPTH)
  ) u_pc_trace_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (trace_we),
    .wr_pc  (pc),
    .rd_idx (trace_idx),
    .rd_pc  (trace_pc)
  );
`endif

endmodule : core_run_monitor

`default_nettype wire
